// File: rtl/add8u_err_meter_pkg.sv
// Shared types and widths for the approximate 8-bit adder error meter.
package add8u_err_meter_pkg;

  localparam int ERR_W = 11;
  localparam int ABS_W = 10;
  localparam int SQ_W  = 18;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/add8u_err_stage.sv
// First pipeline stage: exact sum, signed error and its magnitude, registered.
module add8u_err_stage
  import add8u_err_meter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             take,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [8:0]       o,
  output logic             s1_valid,
  output logic [ABS_W-1:0] s1_abs,
  output logic             s1_nz
);

  logic [8:0]              sum;
  logic signed [ERR_W-1:0] err;
  logic [ERR_W-1:0]        abs_full;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    err      = $signed({2'b00, o}) - $signed({2'b00, sum});
    abs_full = err[ERR_W-1] ? -err : err;
  end

  // Magnitude never exceeds 511, so the top bit of abs_full is always zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_abs   <= '0;
      s1_nz    <= 1'b0;
    end else begin
      s1_valid <= take;
      if (take) begin
        s1_abs <= abs_full[ABS_W-1:0];
        s1_nz  <= (err != '0);
      end
    end
  end

endmodule

// File: rtl/add8u_err_meter.sv
// Error meter: accumulates sample count, error count, SAE, SSE and worst-case
// error of an approximate 8-bit adder over a run, then presents a result bundle.
module add8u_err_meter
  import add8u_err_meter_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SAE_W = 42,
  parameter int SSE_W = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [8:0]       in_o,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_n,
  output logic [CNT_W-1:0] res_nerr,
  output logic [SAE_W-1:0] res_sae,
  output logic [SSE_W-1:0] res_sse,
  output logic [ABS_W-1:0] res_wce,
  output logic             res_sat
);

  state_t state, state_nxt;

  logic             take, clr, to_report;
  logic             s1_valid, s1_nz;
  logic [ABS_W-1:0] s1_abs;
  logic             s2_valid, s2_nz;
  logic [ABS_W-1:0] s2_abs;
  logic [SQ_W-1:0]  s2_sq;

  logic [CNT_W-1:0] acc_n, acc_nerr, n_nxt, nerr_nxt;
  logic [SAE_W-1:0] acc_sae, sae_nxt;
  logic [SSE_W-1:0] acc_sse, sse_nxt;
  logic [ABS_W-1:0] acc_wce, wce_nxt;
  logic             acc_sat, sat_nxt;
  logic [CNT_W:0]   n_add, nerr_add;
  logic [SAE_W:0]   sae_add;
  logic [SSE_W:0]   sse_add;

  assign in_ready  = (state == ACCUM);
  assign res_valid = (state == REPORT);
  assign take      = in_valid & in_ready;
  assign clr       = res_valid & res_ready;
  assign to_report = (state == DRAIN) && (state_nxt == REPORT);

  add8u_err_stage u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .take     (take),
    .a        (in_a),
    .b        (in_b),
    .o        (in_o),
    .s1_valid (s1_valid),
    .s1_abs   (s1_abs),
    .s1_nz    (s1_nz)
  );

  // The last sample sits in S1 on DRAIN entry; once S1 empties, S2 retires it on this edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (take && in_last) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid) state_nxt = REPORT;
      REPORT:  if (res_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    n_add    = {1'b0, acc_n} + {{CNT_W{1'b0}}, 1'b1};
    nerr_add = {1'b0, acc_nerr} + {{CNT_W{1'b0}}, 1'b1};
    sae_add  = {1'b0, acc_sae} + (SAE_W+1)'(s2_abs);
    sse_add  = {1'b0, acc_sse} + (SSE_W+1)'(s2_sq);
    n_nxt    = acc_n;
    nerr_nxt = acc_nerr;
    sae_nxt  = acc_sae;
    sse_nxt  = acc_sse;
    wce_nxt  = acc_wce;
    sat_nxt  = acc_sat;
    if (s2_valid) begin
      n_nxt   = n_add[CNT_W] ? '1 : n_add[CNT_W-1:0];
      sae_nxt = sae_add[SAE_W] ? '1 : sae_add[SAE_W-1:0];
      sse_nxt = sse_add[SSE_W] ? '1 : sse_add[SSE_W-1:0];
      if (s2_nz) nerr_nxt = nerr_add[CNT_W] ? '1 : nerr_add[CNT_W-1:0];
      if (s2_abs > acc_wce) wce_nxt = s2_abs;
      sat_nxt = acc_sat | n_add[CNT_W] | (s2_nz & nerr_add[CNT_W])
              | sae_add[SAE_W] | sse_add[SSE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ACCUM;
      s2_valid <= 1'b0;
      s2_abs   <= '0;
      s2_sq    <= '0;
      s2_nz    <= 1'b0;
      acc_n    <= '0;
      acc_nerr <= '0;
      acc_sae  <= '0;
      acc_sse  <= '0;
      acc_wce  <= '0;
      acc_sat  <= 1'b0;
      res_n    <= '0;
      res_nerr <= '0;
      res_sae  <= '0;
      res_sse  <= '0;
      res_wce  <= '0;
      res_sat  <= 1'b0;
    end else begin
      state    <= state_nxt;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_abs <= s1_abs;
        s2_nz  <= s1_nz;
        s2_sq  <= {{(SQ_W-ABS_W){1'b0}}, s1_abs} * {{(SQ_W-ABS_W){1'b0}}, s1_abs};
      end
      if (clr) begin
        acc_n    <= '0;
        acc_nerr <= '0;
        acc_sae  <= '0;
        acc_sse  <= '0;
        acc_wce  <= '0;
        acc_sat  <= 1'b0;
      end else begin
        acc_n    <= n_nxt;
        acc_nerr <= nerr_nxt;
        acc_sae  <= sae_nxt;
        acc_sse  <= sse_nxt;
        acc_wce  <= wce_nxt;
        acc_sat  <= sat_nxt;
      end
      // Snapshot so the bundle holds its value after the run is consumed.
      if (to_report) begin
        res_n    <= n_nxt;
        res_nerr <= nerr_nxt;
        res_sae  <= sae_nxt;
        res_sse  <= sse_nxt;
        res_wce  <= wce_nxt;
        res_sat  <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_add8u_err_meter.sv
// Randomized bench for add8u_err_meter: default build plus a 4-bit-counter build
// driven by the same stimulus, both checked against plain-arithmetic run totals.
module tb_add8u_err_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0, in_b = '0;
  logic [8:0]  in_o = '0;
  logic        in_last = 1'b0;
  logic        res_ready = 1'b0;

  logic        in_ready, res_valid, res_sat;
  logic [31:0] res_n, res_nerr;
  logic [41:0] res_sae;
  logic [49:0] res_sse;
  logic [9:0]  res_wce;

  logic        in_ready4, res_valid4, res_sat4;
  logic [3:0]  res_n4, res_nerr4;
  logic [41:0] res_sae4;
  logic [49:0] res_sse4;
  logic [9:0]  res_wce4;

  int n_checks = 0;
  int n_fail   = 0;

  int q_a[$], q_b[$], q_o[$];

  always #5 clk = ~clk;

  add8u_err_meter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_o(in_o), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_n(res_n),
    .res_nerr(res_nerr), .res_sae(res_sae), .res_sse(res_sse),
    .res_wce(res_wce), .res_sat(res_sat)
  );

  add8u_err_meter #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_o(in_o), .in_last(in_last),
    .res_valid(res_valid4), .res_ready(res_ready), .res_n(res_n4),
    .res_nerr(res_nerr4), .res_sae(res_sae4), .res_sse(res_sse4),
    .res_wce(res_wce4), .res_sat(res_sat4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input int b, input int o);
    q_a.push_back(a);
    q_b.push_back(b);
    q_o.push_back(o);
  endtask

  task automatic check_bundle(input longint n, input longint nerr, input longint sae,
                              input longint sse, input longint wce);
    check("res_n", res_n, n);
    check("res_nerr", res_nerr, nerr);
    check("res_sae", res_sae, sae);
    check("res_sse", res_sse, sse);
    check("res_wce", res_wce, wce);
    check("res_sat", res_sat, 0);
    check("res_n4", res_n4, (n > 15) ? 15 : n);
    check("res_nerr4", res_nerr4, (nerr > 15) ? 15 : nerr);
    check("res_sae4", res_sae4, sae);
    check("res_sat4", res_sat4, ((n > 15) || (nerr > 15)) ? 1 : 0);
  endtask

  // Sends the queued samples as one run, then checks the report and consumes it.
  task automatic run_stream(input int max_gap, input int hold);
    longint n = 0, nerr = 0, sae = 0, sse = 0, wce = 0;
    int e, ae, lat;
    foreach (q_a[i]) begin
      e  = q_o[i] - (q_a[i] + q_b[i]);
      ae = (e < 0) ? -e : e;
      n++;
      if (e != 0) nerr++;
      sae += ae;
      sse += longint'(ae) * ae;
      if (ae > wce) wce = ae;
    end
    foreach (q_a[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_a = 8'($urandom); in_b = 8'($urandom); in_o = 9'($urandom);
        in_last = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a = 8'(q_a[i]); in_b = 8'(q_b[i]); in_o = 9'(q_o[i]);
      in_last = (i == q_a.size() - 1);
      @(negedge clk);
      check("in_ready_accum", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!res_valid) check("in_ready_drain", in_ready, 0);
    end while (!res_valid && lat < 10);
    check("report_latency", lat, 3);
    check("res_valid4", res_valid4, 1);
    check_bundle(n, nerr, sae, sse, wce);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_a = 8'($urandom); in_b = 8'($urandom); in_o = 9'($urandom);
      in_last = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("in_ready_report", in_ready, 0);
      check("res_valid_hold", res_valid, 1);
      check("res_n_hold", res_n, n);
      check("res_sse_hold", res_sse, sse);
      check("res_wce_hold", res_wce, wce);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_consumed", res_valid, 0);
    check("in_ready_after", in_ready, 1);
    q_a.delete(); q_b.delete(); q_o.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vcount, a, b, len;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_res_valid", res_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_res_n", res_n, 0);
    check("reset_res_wce", res_wce, 0);
    check("reset_res_sat", res_sat, 0);
    @(posedge clk); #1;

    push(100, 50, 150);
    run_stream(0, 5);

    push(10, 5, 0); push(255, 255, 511); push(7, 1, 8);
    run_stream(0, 1);

    push(255, 255, 0); push(0, 0, 511);
    run_stream(0, 0);

    // Reset one cycle after the last sample is accepted: no bundle may appear.
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2; in_o = 9'd7; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) vcount++;
    end
    check("no_report_after_reset", vcount, 0);
    @(posedge clk); #1;
    push(20, 30, 50);
    run_stream(0, 0);

    for (int i = 0; i < 17; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      push(a, b, (i % 3 == 0) ? a + b : $urandom_range(0, 511));
    end
    run_stream(2, 2);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        push(a, b, ($urandom_range(0, 3) == 0) ? a + b : $urandom_range(0, 511));
      end
      run_stream(3, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
